// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store func3 encodings, LSU state type, legality check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cpu_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings share the size field with loads
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int DefaultTimeoutCycles = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    // Unknown encodings, unsigned stores and misaligned halfword/word accesses fault
    function automatic logic access_illegal(input logic       we,
                                            input logic [2:0] func3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111) bad = 1'b1;
        if (we && func3[2])                                        bad = 1'b1;
        if (func3[1:0] == 2'b01 && addr_lo[0])                     bad = 1'b1;
        if (func3[1:0] == 2'b10 && addr_lo != 2'b00)               bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and memory-port bundle for the load/store unit.
// Latency: n/a (wiring only).
// Backpressure: req_ready_o/busy_o stall the pipeline; mem_gnt_i holds the memory request.
interface load_store_unit_if #(
    parameter int AddrWidth = 32
) ();

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [2:0]           req_func3_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [31:0]          req_wdata_i;

    logic                 rsp_valid_o;
    logic [31:0]          rsp_rdata_o;
    logic                 rsp_err_o;
    logic                 busy_o;

    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [3:0]           mem_be_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [31:0]          mem_wdata_o;
    logic                 mem_gnt_i;
    logic                 mem_rvalid_i;
    logic [31:0]          mem_rdata_i;

    // The unit itself
    modport slave (
        input  req_valid_i, req_we_i, req_func3_i, req_addr_i, req_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    // Pipeline plus memory environment driving the unit
    modport master (
        output req_valid_i, req_we_i, req_func3_i, req_addr_i, req_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/lsu_align.sv
// Lane formatting: store data/byte-enable placement and load shift/extension.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
    import cpu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_fmt
);

    logic [31:0] shifted;

    // Store side: move right-aligned data onto its byte lanes; loads read the full word
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        if (we) begin
            case (func3[1:0])
                2'b00: begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
                end
                2'b01: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {16'b0, wdata[15:0]} << {addr_lo[1], 4'b0000};
                end
                default: begin
                    be         = 4'b1111;
                    wdata_lane = wdata;
                end
            endcase
        end
    end

    // Load side: bring the addressed lane down to bit 0 and extend
    always_comb begin
        shifted = mem_rdata >> {addr_lo, 3'b000};
        case (func3)
            F3_LB:   rdata_fmt = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_fmt = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata_fmt = mem_rdata;
            F3_LBU:  rdata_fmt = {24'b0, shifted[7:0]};
            F3_LHU:  rdata_fmt = {16'b0, shifted[15:0]};
            default: rdata_fmt = 32'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: pipeline request -> memory access -> one-cycle response.
// Latency: 3 cycles minimum from acceptance to rsp_valid_o; faults respond 1 cycle after acceptance.
// Backpressure: req_ready_o only in IDLE; mem outputs held until mem_gnt_i; access aborts after TimeoutCycles.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic               clk,
    input  logic               rstn,
    load_store_unit_if.slave   bus
);

    localparam int             CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    lsu_state_t           state;
    logic                 we_q;
    logic [2:0]           func3_q;
    logic [AddrWidth-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [CntW-1:0]      cnt;
    logic [31:0]          rdata_q;
    logic                 err_q;

    logic [3:0]           be_lane;
    logic [31:0]          wdata_lane;
    logic [31:0]          rdata_fmt;
    logic                 in_access;

    lsu_align u_align (
        .we         (we_q),
        .func3      (func3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .mem_rdata  (bus.mem_rdata_i),
        .be         (be_lane),
        .wdata_lane (wdata_lane),
        .rdata_fmt  (rdata_fmt)
    );

    // Request capture, access sequencing and timeout; err/rdata are only non-zero in RESP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            func3_q <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            cnt     <= '0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        we_q    <= bus.req_we_i;
                        func3_q <= bus.req_func3_i;
                        addr_q  <= bus.req_addr_i;
                        wdata_q <= bus.req_wdata_i;
                        cnt     <= '0;
                        rdata_q <= 32'b0;
                        if (access_illegal(bus.req_we_i, bus.req_func3_i, bus.req_addr_i[1:0])) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_gnt_i) begin
                        state <= ST_WAIT;
                    end else if (cnt == CntLast) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_rvalid_i) begin
                        rdata_q <= we_q ? 32'b0 : rdata_fmt;
                        state   <= ST_RESP;
                    end else if (cnt == CntLast) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                default: begin
                    rdata_q <= 32'b0;
                    err_q   <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);

    assign bus.req_ready_o = (state == ST_IDLE);
    assign bus.busy_o      = (state != ST_IDLE);
    assign bus.rsp_valid_o = (state == ST_RESP);
    assign bus.rsp_err_o   = err_q;
    assign bus.rsp_rdata_o = rdata_q;

    // Memory port is quiet outside ACCESS so nothing stale leaks after a response or reset
    assign bus.mem_req_o   = in_access;
    assign bus.mem_we_o    = in_access & we_q;
    assign bus.mem_be_o    = in_access ? be_lane    : 4'b0;
    assign bus.mem_addr_o  = in_access ? addr_q     : '0;
    assign bus.mem_wdata_o = in_access ? wdata_lane : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TimeoutCycles=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each task checks its own scenario inline.
module tb_load_store_unit;
    import cpu_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    load_store_unit_if #(.AddrWidth(32)) bus ();

    load_store_unit #(.AddrWidth(32), .TimeoutCycles(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_func3_i  = 3'b0;
        bus.req_addr_i   = 32'b0;
        bus.req_wdata_i  = 32'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'b0;
    endtask

    // One-cycle request pulse; returns in the cycle after the acceptance edge
    task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_func3_i = f3;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wd;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        total++; if ({bus.req_ready_o, bus.busy_o, bus.rsp_valid_o, bus.rsp_err_o} !== 4'b1000) begin bad++; $display("FAIL reset_ctl: got %b want 1000", {bus.req_ready_o, bus.busy_o, bus.rsp_valid_o, bus.rsp_err_o}); end
        total++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 6'b0) begin bad++; $display("FAIL reset_mem_ctl: got %b want 000000", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}); end
        total++; if ((bus.mem_addr_o | bus.mem_wdata_o | bus.rsp_rdata_o) !== 32'h0) begin bad++; $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", bus.mem_addr_o, bus.mem_wdata_o, bus.rsp_rdata_o); end
        rstn = 1'b1;
        tick();
        total++; if ({bus.req_ready_o, bus.busy_o} !== 2'b10) begin bad++; $display("FAIL post_reset_idle: got %b want 10", {bus.req_ready_o, bus.busy_o}); end
    endtask

    task automatic test_lw();
        total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL lw_ready_before: got %b want 1", bus.req_ready_o); end
        present(1'b0, F3_LW, 32'h100, 32'h0);
        total++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.busy_o, bus.req_ready_o} !== 8'b10_1111_10) begin bad++; $display("FAIL lw_access: got %b want 10111110", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.busy_o, bus.req_ready_o}); end
        total++; if (bus.mem_addr_o !== 32'h100) begin bad++; $display("FAIL lw_addr: got %h want 00000100", bus.mem_addr_o); end
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        total++; if ({bus.mem_req_o, bus.rsp_valid_o, bus.busy_o} !== 3'b001) begin bad++; $display("FAIL lw_wait: got %b want 001", {bus.mem_req_o, bus.rsp_valid_o, bus.busy_o}); end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEADBEEF;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        total++; if ({bus.rsp_valid_o, bus.rsp_err_o} !== 2'b10) begin bad++; $display("FAIL lw_rsp: got %b want 10", {bus.rsp_valid_o, bus.rsp_err_o}); end
        total++; if (bus.rsp_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got %h want deadbeef", bus.rsp_rdata_o); end
        tick();
        total++; if ({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_rdata_o} !== {2'b01, 32'h0}) begin bad++; $display("FAIL lw_after: valid %b ready %b rdata %h want 0 1 0", bus.rsp_valid_o, bus.req_ready_o, bus.rsp_rdata_o); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [7];
        logic [31:0] ad [7];
        logic [31:0] rd [7];
        logic [31:0] ex [7];
        f3 = '{F3_LB,        F3_LBU,       F3_LH,        F3_LHU,       F3_LB,        F3_LBU,       F3_LH};
        ad = '{32'h103,      32'h103,      32'h102,      32'h102,      32'h102,      32'h101,      32'h100};
        rd = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h12345678, 32'h12347FFE};
        ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'hFFFFFFFF, 32'h00000056, 32'h00007FFE};
        for (int i = 0; i < 7; i++) begin
            present(1'b0, f3[i], ad[i], 32'h0);
            total++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {6'b10_1111, ad[i]}) begin bad++; $display("FAIL load%0d_access: req %b we %b be %b addr %h want 1 0 1111 %h", i, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, ad[i]); end
            bus.mem_gnt_i = 1'b1;
            tick();
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rd[i];
            tick();
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = 32'h0;
            total++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {2'b10, ex[i]}) begin bad++; $display("FAIL load%0d_rsp: valid %b err %b rdata %h want 1 0 %h", i, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, ex[i]); end
            tick();
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3 [5];
        logic [31:0] ad [5];
        logic [31:0] wd [5];
        logic [3:0]  eb [5];
        logic [31:0] ew [5];
        int          dl [5];
        f3 = '{F3_SH,        F3_SB,        F3_SW,        F3_SH,        F3_SB};
        ad = '{32'h202,      32'h201,      32'h200,      32'h200,      32'h203};
        wd = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D, 32'h1234ABCD, 32'h11223344};
        eb = '{4'b1100,      4'b0010,      4'b1111,      4'b0011,      4'b1000};
        ew = '{32'hABCD0000, 32'h0000A500, 32'hCAFEF00D, 32'h0000ABCD, 32'h44000000};
        dl = '{2, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            present(1'b1, f3[i], ad[i], wd[i]);
            for (int k = 0; k <= dl[i]; k++) begin
                total++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_addr_o} !== {2'b11, eb[i], ew[i], ad[i]}) begin bad++; $display("FAIL store%0d_lane_c%0d: req %b we %b be %b wdata %h addr %h want 1 1 %b %h %h", i, k, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_addr_o, eb[i], ew[i], ad[i]); end
                if (k < dl[i]) tick();
            end
            bus.mem_gnt_i = 1'b1;
            tick();
            bus.mem_gnt_i = 1'b0;
            total++; if ({bus.mem_req_o, bus.rsp_valid_o} !== 2'b00) begin bad++; $display("FAIL store%0d_wait: req %b valid %b want 0 0", i, bus.mem_req_o, bus.rsp_valid_o); end
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hFFFFFFFF;
            tick();
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = 32'h0;
            total++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {2'b10, 32'h0}) begin bad++; $display("FAIL store%0d_rsp: valid %b err %b rdata %h want 1 0 0", i, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o); end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic        we [8];
        logic [2:0]  f3 [8];
        logic [31:0] ad [8];
        we = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        f3 = '{F3_LW,   3'b011,  3'b100,  F3_LH,   F3_SW,   3'b111,  3'b101,  3'b110};
        ad = '{32'h101, 32'h100, 32'h100, 32'h101, 32'h102, 32'h100, 32'h100, 32'h0};
        bus.mem_rdata_i = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            present(we[i], f3[i], ad[i], 32'h55555555);
            total++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.rsp_rdata_o} !== {3'b110, 32'h0}) begin bad++; $display("FAIL illegal%0d_rsp: valid %b err %b memreq %b rdata %h want 1 1 0 0", i, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.rsp_rdata_o); end
            tick();
            total++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.req_ready_o, bus.mem_req_o} !== 4'b0010) begin bad++; $display("FAIL illegal%0d_after: got %b want 0010", i, {bus.rsp_valid_o, bus.rsp_err_o, bus.req_ready_o, bus.mem_req_o}); end
        end
        bus.mem_rdata_i = 32'h0;
    endtask

    task automatic test_timeout();
        int cyc;
        int reqs;
        // Grant never arrives
        present(1'b0, F3_LW, 32'h300, 32'h0);
        cyc  = 1;
        reqs = 0;
        while (!bus.rsp_valid_o && cyc < 30) begin
            if (bus.mem_req_o) reqs++;
            tick();
            cyc++;
        end
        total++; if (cyc !== 9) begin bad++; $display("FAIL timeout_gnt_cycle: response in cycle %0d want 9", cyc); end
        total++; if (reqs !== 8) begin bad++; $display("FAIL timeout_gnt_reqs: mem_req cycles %0d want 8", reqs); end
        total++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.rsp_rdata_o} !== {3'b110, 32'h0}) begin bad++; $display("FAIL timeout_gnt_rsp: valid %b err %b memreq %b rdata %h want 1 1 0 0", bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.rsp_rdata_o); end
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h12345678;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        total++; if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin bad++; $display("FAIL timeout_late_rvalid: valid %b ready %b want 0 1", bus.rsp_valid_o, bus.req_ready_o); end
        tick();
        total++; if ({bus.rsp_valid_o, bus.busy_o} !== 2'b00) begin bad++; $display("FAIL timeout_late_rvalid2: valid %b busy %b want 0 0", bus.rsp_valid_o, bus.busy_o); end
        // Grant arrives but read data never does
        present(1'b0, F3_LW, 32'h304, 32'h0);
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        cyc = 2;
        while (!bus.rsp_valid_o && cyc < 30) begin
            tick();
            cyc++;
        end
        total++; if (cyc !== 9) begin bad++; $display("FAIL timeout_wait_cycle: response in cycle %0d want 9", cyc); end
        total++; if ({bus.rsp_valid_o, bus.rsp_err_o} !== 2'b11) begin bad++; $display("FAIL timeout_wait_rsp: valid %b err %b want 1 1", bus.rsp_valid_o, bus.rsp_err_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_func3_i = F3_LW;
        bus.req_addr_i  = 32'h400;
        tick();
        // rvalid during ACCESS must not complete the access
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0BAD0;
        tick();
        bus.mem_rvalid_i = 1'b0;
        total++; if ({bus.mem_req_o, bus.rsp_valid_o, bus.req_ready_o} !== 3'b100) begin bad++; $display("FAIL b2b_rvalid_in_access: got %b want 100", {bus.mem_req_o, bus.rsp_valid_o, bus.req_ready_o}); end
        total++; if (bus.mem_addr_o !== 32'h400) begin bad++; $display("FAIL b2b_addr_held: got %h want 00000400", bus.mem_addr_o); end
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        total++; if ({bus.mem_req_o, bus.req_ready_o, bus.busy_o} !== 3'b001) begin bad++; $display("FAIL b2b_held_not_taken: got %b want 001", {bus.mem_req_o, bus.req_ready_o, bus.busy_o}); end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h01020304;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        total++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, 32'h01020304}) begin bad++; $display("FAIL b2b_rsp1: valid %b rdata %h want 1 01020304", bus.rsp_valid_o, bus.rsp_rdata_o); end
        bus.req_addr_i = 32'h408;
        tick();
        total++; if ({bus.req_ready_o, bus.mem_req_o} !== 2'b10) begin bad++; $display("FAIL b2b_idle: got %b want 10", {bus.req_ready_o, bus.mem_req_o}); end
        tick();
        bus.req_valid_i = 1'b0;
        total++; if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h408}) begin bad++; $display("FAIL b2b_second: req %b addr %h want 1 00000408", bus.mem_req_o, bus.mem_addr_o); end
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hA5A5A5A5;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        total++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, 32'hA5A5A5A5}) begin bad++; $display("FAIL b2b_rsp2: valid %b rdata %h want 1 a5a5a5a5", bus.rsp_valid_o, bus.rsp_rdata_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        present(1'b0, F3_LW, 32'h500, 32'h0);
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL midrst_in_wait: busy %b want 1", bus.busy_o); end
        rstn = 1'b0;
        #1;
        total++; if ({bus.req_ready_o, bus.busy_o, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 10'b10_0000_0000) begin bad++; $display("FAIL midrst_outputs: got %b want 1000000000", {bus.req_ready_o, bus.busy_o, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}); end
        total++; if ((bus.mem_addr_o | bus.mem_wdata_o | bus.rsp_rdata_o) !== 32'h0) begin bad++; $display("FAIL midrst_data: addr %h wdata %h rdata %h want 0", bus.mem_addr_o, bus.mem_wdata_o, bus.rsp_rdata_o); end
        tick();
        tick();
        rstn = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hFEEDFACE;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        total++; if ({bus.rsp_valid_o, bus.req_ready_o, bus.busy_o} !== 3'b010) begin bad++; $display("FAIL midrst_stale_rvalid: got %b want 010", {bus.rsp_valid_o, bus.req_ready_o, bus.busy_o}); end
        tick();
        total++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== 33'h0) begin bad++; $display("FAIL midrst_quiet: valid %b rdata %h want 0 0", bus.rsp_valid_o, bus.rsp_rdata_o); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter AddrWidth, default 32: width of the request and memory address.
REQ-002 Parameter TimeoutCycles, default 256: maximum number of cycles spent in ACCESS plus WAIT before the access is aborted.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 req_valid_i  in  1  pipeline request valid.
REQ-006 req_ready_o  out  1  unit can accept a request.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_func3_i  in  3  access type: LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-009 req_addr_i  in  AddrWidth  byte address.
REQ-010 req_wdata_i  in  32  store data, right-aligned.
REQ-011 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata_o  out  32  aligned, extended load data.
REQ-013 rsp_err_o  out  1  access faulted; valid only with rsp_valid_o.
REQ-014 busy_o  out  1  request in flight; the pipeline stalls on this signal.
REQ-015 mem_req_o  out  1  memory request.
REQ-016 mem_we_o  out  1  memory write.
REQ-017 mem_be_o  out  4  active-high byte enables.
REQ-018 mem_addr_o  out  AddrWidth  memory address.
REQ-019 mem_wdata_o  out  32  lane-positioned store data.
REQ-020 mem_gnt_i  in  1  memory accepted the request.
REQ-021 mem_rvalid_i  in  1  read data valid or write acknowledge.
REQ-022 mem_rdata_i  in  32  memory read word.

Function
REQ-023 FSM states: IDLE, ACCESS, WAIT, RESP; req_ready_o = (state == IDLE); busy_o = (state != IDLE).
REQ-024 Acceptance: req_valid_i && req_ready_o at a clock edge; the request fields are registered, and a legal access moves IDLE->ACCESS.
REQ-025 Illegal access (func3 011/110/111; store func3 with bit 2 set; halfword with addr[0]=1; word with addr[1:0]!=0): IDLE->RESP, rsp_err_o=1, no mem_req_o pulse.
REQ-026 In ACCESS: mem_req_o=1 and all mem_* outputs driven from registers and held stable until mem_gnt_i; on grant, ACCESS->WAIT.
REQ-027 In WAIT: on mem_rvalid_i, capture the formatted data and move WAIT->RESP; mem_rvalid_i is ignored in every other state.
REQ-028 RESP lasts exactly one cycle with rsp_valid_o=1, then returns to IDLE; minimum latency from acceptance edge to rsp_valid_o is 3 cycles.
REQ-029 Store lanes: SB places byte at lane addr[1:0], be=0001<<addr[1:0]; SH places halfword at lane addr[1]*2, be=0011 or 1100; SW uses be=1111.
REQ-030 Loads: mem_be_o=1111; data right-shifted by addr[1:0]*8; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-031 rsp_rdata_o=0 for stores and for any errored response.
REQ-032 Timeout: a counter clears on acceptance and increments each cycle in ACCESS/WAIT; if it reaches TimeoutCycles-1 with no state progress, go to RESP with rsp_err_o=1 and drop mem_req_o.
REQ-033 A request presented while busy is not accepted; the requester holds it.

Reset
REQ-034 While rstn=0: state=IDLE, counter=0, all outputs 0 except req_ready_o, which is 1 once reset is asserted.
REQ-035 Reset mid-access aborts immediately; no response is generated, and stale mem_rvalid_i after release is ignored.

Structure
REQ-036 The func3 encodings, the state enum type and the default TimeoutCycles SHALL live in the shared cpu_pkg.
REQ-037 Lane formatting (store shift/byte enable, load shift/extend) SHALL be a combinational sub-module lsu_align.

Verification
REQ-038 LW addr 0x100, gnt at cycle 1, rvalid at cycle 2, rdata 0xDEADBEEF -> rsp_valid_o in cycle 3 with 0xDEADBEEF, err=0.
REQ-039 LB addr 0x103, rdata 0x80FF_0000 -> 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SH addr 0x202, wdata 0x1234ABCD -> mem_be_o=1100, mem_wdata_o=0xABCD0000, and a response after the rvalid acknowledge.
REQ-041 LW addr 0x101 -> rsp_err_o=1 in the cycle after acceptance, and mem_req_o never asserted.
REQ-042 Grant withheld, TimeoutCycles=8 -> mem_req_o held 8 cycles, then rsp_err_o=1; a late rvalid causes no further response.
REQ-043 rstn low while in WAIT -> all outputs 0 and req_ready_o=1 after reset, with no rsp_valid_o.
